// File: rtl/scm_asymm_win_pkg.sv
// Shared types and width helper for the asymmetric SCM port-b window sequencer.
package scm_asymm_win_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } win_state_e;

    function automatic int unsigned win_width(input int unsigned factor, input int unsigned data_w);
        return factor * data_w;
    endfunction

endpackage

// File: rtl/scm_asymm_win_skid.sv
// Two-entry valid/ready skid buffer; in_ready_o depends only on registered occupancy.
module scm_asymm_win_skid #(
    parameter int unsigned WIDTH = 97
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Payload storage needs no reset; occupancy qualifies it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/scm_asymm_window_ctrl.sv
// Command-driven window sequencer owning port b of the asymmetric SCM register file.
// Optional skid buffer on the window stream: define SCM_ASYMM_WIN_SKID_EN.
module scm_asymm_window_ctrl
    import scm_asymm_win_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ASYMM_FACTOR = 3,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]                cmd_base_i,
    input  logic [ADDR_WIDTH-1:0]                cmd_stride_i,
    input  logic [CNT_WIDTH-1:0]                 cmd_len_i,
    input  logic                                 flush_i,
    output logic                                 win_valid_o,
    input  logic                                 win_ready_i,
    output logic [ASYMM_FACTOR*DATA_WIDTH-1:0]   win_data_o,
    output logic                                 win_last_o,
    output logic                                 done_o,
    output logic                                 rf_ReadEnable_b_o,
    output logic [ADDR_WIDTH-1:0]                rf_ReadAddr_b_o,
    input  logic [ASYMM_FACTOR*DATA_WIDTH-1:0]   rf_ReadData_b_i
);

    localparam int unsigned WIN_W = win_width(ASYMM_FACTOR, DATA_WIDTH);

    win_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue;
    logic                  cmd_hs;

    assign cmd_hs = cmd_valid_i && (state_q == IDLE) && !flush_i;

`ifdef SCM_ASYMM_WIN_SKID_EN
    // rf_vld_q marks an unconsumed word sitting in the RF output register.
    logic             rf_vld_q, rf_vld_d;
    logic             rf_last_q, rf_last_d;
    logic             skid_in_ready;
    logic             skid_push;
    logic             win_hs;
    logic [WIN_W:0]   skid_out;

    assign skid_push = rf_vld_q && skid_in_ready;
    assign win_hs    = win_valid_o && win_ready_i;

    scm_asymm_win_skid #(.WIDTH(WIN_W + 1)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (rf_vld_q),
        .in_ready_o  (skid_in_ready),
        .in_data_i   ({rf_last_q, rf_ReadData_b_i}),
        .out_valid_o (win_valid_o),
        .out_ready_i (win_ready_i),
        .out_data_o  (skid_out)
    );

    assign win_last_o = win_valid_o && skid_out[WIN_W];
    assign win_data_o = skid_out[WIN_W-1:0];
`else
    // The RF address register holds the window, so data passes straight through.
    assign win_valid_o = (state_q == STREAM);
    assign win_last_o  = win_valid_o && (rem_q == '0);
    assign win_data_o  = rf_ReadData_b_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            stride_q <= '0;
            rem_q    <= '0;
`ifdef SCM_ASYMM_WIN_SKID_EN
            rf_vld_q  <= 1'b0;
            rf_last_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
`ifdef SCM_ASYMM_WIN_SKID_EN
            rf_vld_q  <= rf_vld_d;
            rf_last_q <= rf_last_d;
`endif
        end
    end

    // Next state, walker registers and the read-issue decision.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        stride_d   = stride_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_addr = '0;
`ifdef SCM_ASYMM_WIN_SKID_EN
        rf_vld_d   = rf_vld_q && !skid_push;
        rf_last_d  = rf_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (cmd_len_i != '0) begin
                        issue      = 1'b1;
                        issue_addr = cmd_base_i;
                        cur_d      = cmd_base_i;
                        stride_d   = cmd_stride_i;
                        rem_d      = cmd_len_i - CNT_WIDTH'(1);
`ifdef SCM_ASYMM_WIN_SKID_EN
                        rf_last_d  = (cmd_len_i == CNT_WIDTH'(1));
`endif
                        state_d    = STREAM;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            STREAM: begin
`ifdef SCM_ASYMM_WIN_SKID_EN
                if ((rem_q != '0) && (!rf_vld_q || skid_in_ready)) begin
                    issue      = 1'b1;
                    issue_addr = cur_q + stride_q;
                    cur_d      = issue_addr;
                    rem_d      = rem_q - CNT_WIDTH'(1);
                    rf_last_d  = (rem_q == CNT_WIDTH'(1));
                end
                if (win_hs && win_last_o) state_d = FIN;
`else
                if (win_ready_i) begin
                    if (rem_q != '0) begin
                        issue      = 1'b1;
                        issue_addr = cur_q + stride_q;
                        cur_d      = issue_addr;
                        rem_d      = rem_q - CNT_WIDTH'(1);
                    end else begin
                        state_d = FIN;
                    end
                end
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef SCM_ASYMM_WIN_SKID_EN
        if (issue) rf_vld_d = 1'b1;
`endif
        if (flush_i) begin
            state_d    = IDLE;
            cur_d      = cur_q;
            rem_d      = rem_q;
            issue      = 1'b0;
            issue_addr = '0;
`ifdef SCM_ASYMM_WIN_SKID_EN
            rf_vld_d   = 1'b0;
`endif
        end
    end

    // Handshake, completion and RF port-b outputs.
    always_comb begin
        cmd_ready_o       = 1'b0;
        done_o            = 1'b0;
        rf_ReadEnable_b_o = 1'b0;
        rf_ReadAddr_b_o   = '0;
        if (!flush_i) begin
            cmd_ready_o = (state_q == IDLE);
            done_o      = (state_q == FIN);
        end
        if (issue) begin
            rf_ReadEnable_b_o = 1'b1;
            rf_ReadAddr_b_o   = issue_addr;
        end
    end

endmodule

// File: tb/tb_scm_asymm_window_ctrl.sv
// Scoreboard bench for scm_asymm_window_ctrl against a behavioural port-b RF model.
module tb_scm_asymm_window_ctrl;

`ifdef SCM_ASYMM_WIN_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [4:0]  cmd_base_i;
    logic [4:0]  cmd_stride_i;
    logic [7:0]  cmd_len_i;
    logic        flush_i;
    logic        win_valid_o;
    logic        win_ready_i;
    logic [95:0] win_data_o;
    logic        win_last_o;
    logic        done_o;
    logic        rf_ReadEnable_b_o;
    logic [4:0]  rf_ReadAddr_b_o;
    logic [95:0] rf_ReadData_b_i;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b1;

    logic [96:0] exp_win_q [$];
    int          exp_addr_q [$];

    scm_asymm_window_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_base_i        (cmd_base_i),
        .cmd_stride_i      (cmd_stride_i),
        .cmd_len_i         (cmd_len_i),
        .flush_i           (flush_i),
        .win_valid_o       (win_valid_o),
        .win_ready_i       (win_ready_i),
        .win_data_o        (win_data_o),
        .win_last_o        (win_last_o),
        .done_o            (done_o),
        .rf_ReadEnable_b_o (rf_ReadEnable_b_o),
        .rf_ReadAddr_b_o   (rf_ReadAddr_b_o),
        .rf_ReadData_b_i   (rf_ReadData_b_i)
    );

    always #5 clk = ~clk;

    // Port-b RF model: address registered on enable, 3-word circular window.
    logic [31:0] rf_mem [32];
    logic [4:0]  rf_addr_q = 5'd0;
    always @(posedge clk) if (rf_ReadEnable_b_o) rf_addr_q <= rf_ReadAddr_b_o;
    assign rf_ReadData_b_i = {rf_mem[5'(rf_addr_q + 5'd2)], rf_mem[5'(rf_addr_q + 5'd1)], rf_mem[rf_addr_q]};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [96:0] exp_win(input int a, input bit last);
        return {last, 32'((a + 2) % 32), 32'((a + 1) % 32), 32'(a % 32)};
    endfunction

    // Monitor: window/address scoreboard and stall-stability check.
    bit          stall_q = 1'b0;
    logic [95:0] hold_q;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (win_valid_o && stall_q) chk("hold", win_data_o, hold_q);
            if (win_valid_o && win_ready_i) begin
                if (exp_win_q.size() == 0) chk("win_extra", 1, 0);
                else chk("win", {win_last_o, win_data_o}, exp_win_q.pop_front());
            end
            if (rf_ReadEnable_b_o) begin
                if (exp_addr_q.size() == 0) chk("addr_extra", 1, 0);
                else chk("addr", rf_ReadAddr_b_o, exp_addr_q.pop_front());
            end
            stall_q = win_valid_o && !win_ready_i && !flush_i;
            hold_q  = win_data_o;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, win_valid_o, 0);
        chk({tag, "_last"}, win_last_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
        chk({tag, "_rf_en"}, rf_ReadEnable_b_o, 0);
        chk({tag, "_rf_addr"}, rf_ReadAddr_b_o, 0);
    endtask

    task automatic run_cmd(input int base, input int stride, input int len, input bit toggle);
        int first_c = 0;
        int done_c  = 0;
        for (int k = 0; k < len; k++) begin
            int a = (base + k * stride) % 32;
            exp_addr_q.push_back(a);
            exp_win_q.push_back(exp_win(a, k == len - 1));
        end
        cmd_base_i   = 5'(base);
        cmd_stride_i = 5'(stride);
        cmd_len_i    = 8'(len);
        cmd_valid_i  = 1'b1;
        win_ready_i  = 1'b1;
        @(negedge clk);
        chk("cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int c = 1; c <= 2000 && done_c == 0; c++) begin
            win_ready_i = toggle ? ((c % 3) == 1) : 1'b1;
            @(negedge clk);
            if (win_valid_o && first_c == 0) first_c = c;
            if (done_o) done_c = c;
            @(posedge clk); #1;
        end
        win_ready_i = 1'b0;
        chk("done_seen", done_c != 0, 1);
        chk("first_lat", first_c, (len == 0) ? 0 : LAT);
        if (!toggle) chk("done_lat", done_c, (len == 0) ? 1 : LAT + len);
        chk("win_q_empty", exp_win_q.size(), 0);
        chk("addr_q_empty", exp_addr_q.size(), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_base_i   = '0;
        cmd_stride_i = '0;
        cmd_len_i    = '0;
        flush_i      = 1'b0;
        win_ready_i  = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i);
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(4, 1, 3, 1'b0);
        run_cmd(30, 1, 4, 1'b0);
        run_cmd(0, 8, 4, 1'b1);
        run_cmd(0, 0, 0, 1'b0);
        run_cmd(7, 0, 2, 1'b0);

        // Flush on the second window: only the first is consumed.
        for (int k = 0; k <= LAT; k++) exp_addr_q.push_back((10 + 2 * k) % 32);
        exp_win_q.push_back(exp_win(10, 1'b0));
        cmd_base_i = 5'd10; cmd_stride_i = 5'd2; cmd_len_i = 8'd5; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        win_ready_i = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            @(posedge clk); #1;
        end
        win_ready_i = 1'b0;
        flush_i     = 1'b1;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        chk("flush_cmd_ready", cmd_ready_o, 0);
        chk("flush_rf_en", rf_ReadEnable_b_o, 0);
        chk("flush_done", done_o, 0);
        @(posedge clk); #1;
        flush_i     = 1'b0;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", win_valid_o, 0);
        chk("post_flush_done", done_o, 0);
        chk("post_flush_cmd_ready", cmd_ready_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_flush_done2", done_o, 0);
        @(posedge clk); #1;
        chk("flush_win_q", exp_win_q.size(), 0);
        chk("flush_addr_q", exp_addr_q.size(), 0);
        run_cmd(4, 1, 3, 1'b0);

        // Asynchronous reset in the middle of a stream.
        mon_en = 1'b0;
        cmd_base_i = 5'd0; cmd_stride_i = 5'd1; cmd_len_i = 8'd5; cmd_valid_i = 1'b1;
        win_ready_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        win_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_win_q.delete();
        exp_addr_q.delete();
        mon_en = 1'b1;
        run_cmd(4, 1, 3, 1'b0);

        run_cmd(3, 5, 255, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scm_asymm_window_ctrl.md
Name: scm_asymm_window_ctrl

Overview:
- Command-driven sequencer for the asymmetric read port (port b) of the 2R/1W asymmetric SCM register file.
- Accepts a command {base, stride, len} and walks port b through len windows of ASYMM_FACTOR words each, at base, base+stride, base+2*stride, ...
- Presents each window on a valid/ready stream toward a consumer, e.g. a sliding-window datapath.
- Owns port b exclusively. The write port and port a are untouched.

Parameters:
- ADDR_WIDTH, 5, RF address width; RF depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RF word width.
- ASYMM_FACTOR, 3, words per window; must match the RF instance.
- CNT_WIDTH, 8, width of the window-count field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_base_i  in  ADDR_WIDTH  first window address
- cmd_stride_i  in  ADDR_WIDTH  address increment between windows
- cmd_len_i  in  CNT_WIDTH  number of windows; 0 is legal
- flush_i  in  1  synchronous abort
- win_valid_o  out  1  window valid
- win_ready_i  in  1  window ready
- win_data_o  out  ASYMM_FACTOR*DATA_WIDTH  window data; word 0 in the LSBs
- win_last_o  out  1  final window of the command
- done_o  out  1  one-cycle pulse when a command completes
- rf_ReadEnable_b_o  out  1  to RF ReadEnable_b
- rf_ReadAddr_b_o  out  ADDR_WIDTH  to RF ReadAddr_b
- rf_ReadData_b_i  in  ASYMM_FACTOR*DATA_WIDTH  from RF ReadData_b

Interface decision:
- One clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- RF port-b contract:
  - The RF registers the address when ReadEnable_b=1.
  - Data is valid from the next cycle and holds while enable stays low.
  - The RF address register therefore acts as the output buffer: no data storage in this block in the base build.
- FSM states: IDLE, STREAM, FIN.
- IDLE:
  - cmd_ready_o=1.
  - On handshake with len!=0: rf_ReadEnable_b_o=1 and rf_ReadAddr_b_o=cmd_base_i in the same cycle. Latch cur=base, stride, rem=len-1. Go to STREAM.
  - On handshake with len==0: no RF access. Go to FIN.
- STREAM:
  - win_valid_o=1; win_data_o=rf_ReadData_b_i; win_last_o=(rem==0). cmd_ready_o=0.
  - On win_ready_i with rem!=0: rf_ReadEnable_b_o=1 with rf_ReadAddr_b_o=cur+stride in the same cycle; cur<=cur+stride; rem<=rem-1. Throughput is 1 window/cycle.
  - On win_ready_i with rem==0: go to FIN.
  - Without win_ready_i: enable stays 0, so data holds stable.
- FIN:
  - done_o=1 for exactly one cycle; cmd_ready_o=0. Next state IDLE.
- Command latency: command handshake at cycle t gives the first window valid at t+1.
- Address arithmetic is modulo 2**ADDR_WIDTH; wrap is silent. Windows straddling the top address are wrapped circularly by the RF.
- rf_ReadAddr_b_o is driven 0 whenever rf_ReadEnable_b_o=0.
- flush_i:
  - Forces IDLE next cycle from any state; no done_o; enable is 0 during the flush cycle.
  - flush_i together with a cmd handshake: flush wins and the command is dropped (cmd_ready_o is 0 while flush_i=1).
- Reset values:
  - State IDLE, cur=0, rem=0.
  - win_valid_o=0, win_last_o=0, done_o=0.
  - cmd_ready_o=1, rf_ReadEnable_b_o=0 (unless cmd_valid_i), rf_ReadAddr_b_o=0.
- Reset mid-stream: same as above; the in-flight window is discarded.
- Stride 0 is legal: repeated reads of the same window.
- len=2**CNT_WIDTH-1 is the maximum.

Optional Feature:
- Macro: SCM_ASYMM_WIN_SKID_EN.
- Defined:
  - Inserts a 2-entry skid buffer between the RF data and win_*.
  - Breaks the combinational win_ready_i -> rf_ReadEnable_b_o path.
  - The sequencer issues reads while the buffer has space.
  - First-window latency becomes 2 cycles; throughput stays 1/cycle.
  - win_last_o travels with the data. done_o fires one cycle after the last window leaves the buffer.
  - flush_i also clears the buffer.
- Undefined: behaviour exactly as above; combinational ready-to-enable path is present.

Decomposition:
- Package scm_asymm_win_pkg holds:
  - state enum win_state_e {IDLE, STREAM, FIN};
  - localparam helper for window width, ASYMM_FACTOR*DATA_WIDTH.
- One sub-module: scm_asymm_win_skid, a 2-entry valid/ready skid buffer carrying {last, data}. Instantiated only under SCM_ASYMM_WIN_SKID_EN.

Test Plan:
- RF preloaded rf[i]=i, ADDR_WIDTH=5, ASYMM_FACTOR=3.
- base=4, stride=1, len=3, win_ready_i=1: windows {6,5,4}, {7,6,5}, {8,7,6} on consecutive cycles; last on the 3rd; done_o one cycle later.
- base=30, stride=1, len=4: windows at 30, 31, 0, 1; first window {0,31,30}, second {1,0,31}; no X.
- base=0, stride=8, len=4, win_ready_i toggling 1,0,0,1,...: each window held stable while stalled, no extra rf_ReadEnable_b_o; addresses 0, 8, 16, 24.
- len=0: accept; no rf_ReadEnable_b_o; done_o at t+1; no win_valid_o.
- len=5, flush_i at 2nd window: win_valid_o=0 next cycle, no done_o, cmd_ready_o=1; a new command runs cleanly.
- rst_n low mid-stream: outputs go to reset values immediately. With SCM_ASYMM_WIN_SKID_EN, rerun the 1st scenario: identical data, first window at t+2.
